cycle_pulse_gen: RTL
====================

Name: cycle_pulse_gen

Overview:
Generates timed start/stop strobe pairs for the cycle timer, on the same clock. Each stop strobe is a programmed number of cycles after its start strobe, so the timer's count output should read back exactly that value. Optional bursts of several pairs are separated by a programmable gap. Used for on-board self-test of the timing path and for latency calibration.

Parameters:
CNT_W, 8, width of delay and gap fields, and width of the internal down-counter
N_W, 4, width of the burst-count field

Ports:
clk        in   1      system clock, all logic on rising edge
reset      in   1      asynchronous, active-high; clears all state
trig_i     in   1      level; sampled in IDLE only; high starts a burst
delay_i    in   CNT_W  start-to-stop distance in cycles; latched at trigger
gap_i      in   CNT_W  idle cycles between a stop and the next start; latched at trigger
count_i    in   N_W    number of pairs in the burst; 0 is treated as 1; latched at trigger
abort_i    in   1      terminates the burst early
sig_start  out  1      one-cycle start strobe, drives the timer's start input
sig_stop   out  1      one-cycle stop strobe, drives the timer's stop input
busy       out  1      high from the cycle after trigger until return to IDLE
done       out  1      one-cycle pulse when a burst completes normally
pulse_idx  out  N_W    index of the current pair, 0-based

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, all latched fields go to 0.
- All outputs are registered.
- State machine: IDLE, START, WAIT, STOP, GAP, FIN.
- IDLE:
  - If trig_i = 1 at a clock edge, latch delay_i, gap_i and count_i (0 becomes 1).
  - Clear pulse_idx and go to START.
- START:
  - sig_start = 1 for exactly this cycle.
  - If delay = 0: sig_stop is also 1 in this same cycle, and the next state is per the STOP rules.
  - If delay > 0: load the counter with delay-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, go to STOP.
- Stop timing: sig_stop rises exactly delay cycles after sig_start. If sig_start is high in cycle T, sig_stop is high in cycle T+delay.
- STOP:
  - sig_stop = 1 for exactly this cycle.
  - If pulse_idx = count-1, go to FIN.
  - Otherwise increment pulse_idx. If gap = 0, go directly to START; else load the counter with gap-1 and go to GAP.
- GAP: decrement the counter; when it is 0, go to START.
- FIN: done = 1 for one cycle, then go to IDLE.
- busy is 1 in every state except IDLE.
- Re-trigger: trig_i is ignored outside IDLE. A held trig_i restarts a new burst on the first IDLE cycle after FIN, so back-to-back bursts are allowed.
- abort_i, which has priority over normal transitions:
  - In WAIT: go to STOP with the stop pulse issued, so the timer is never left running; then go to IDLE; done is not asserted.
  - In START with delay > 0: behaves as in WAIT.
  - In GAP or FIN: go to IDLE immediately.
  - In STOP: complete the stop pulse, then go to IDLE.
  - In IDLE: no effect, and abort wins over trig_i in the same cycle.
- Width rules:
  - The counter is CNT_W bits; delay = 2^CNT_W-1 must work without wrap.
  - pulse_idx saturates at count-1, never wraps.
- sig_start and sig_stop are never both 1 except when delay = 0.

Decomposition:
- Shared package:
  - State encoding as a localparam set: IDLE=0, START=1, WAIT=2, STOP=3, GAP=4, FIN=5.
  - Default widths CNT_W and N_W.
- One natural sub-module: cpg_downcnt, a loadable CNT_W down-counter with a zero flag, reused for both the WAIT and GAP phases.
- The FSM stays in the top module.

Test Plan:
1. delay=5, count=1, gap=0, trig for 1 cycle -> sig_start at T, sig_stop at T+5, done at T+6; the attached timer reads 5.
2. delay=0 -> sig_start and sig_stop in the same cycle; the timer reads 0; done in the next cycle.
3. delay=3, gap=2, count=3 -> start strobes at T, T+6, T+12; stops at T+3, T+9, T+15; pulse_idx 0, 1, 2; a single done at T+16.
4. delay=255 (CNT_W=8) -> stop exactly 255 cycles after start; the counter does not wrap.
5. delay=20, abort raised 7 cycles after start -> sig_stop in the next cycle, no done, busy drops the cycle after; a new trigger then works normally.
6. Reset asserted asynchronously mid-WAIT -> all outputs are 0 immediately, without waiting for a clock edge; no stray sig_stop after release.

Source files
------------

// File: rtl/cycle_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_pulse_gen_pkg
// Purpose  : Shared definitions for the cycle timer self-test strobe generator:
//            default field widths and the burst state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cycle_pulse_gen_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_N_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } cpg_state_t;

endpackage
`default_nettype wire

// File: rtl/cpg_downcnt.sv
`default_nettype none
// ============================================================================
// Module   : cpg_downcnt
// Purpose  : Loadable down-counter with a zero flag. Shared by the delay
//            (WAIT) and gap (GAP) phases of the strobe generator.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-high clear
//            load_i     - load load_val_i (wins over dec_i)
//            load_val_i - value to load
//            dec_i      - decrement by one, holds at zero
//            zero_o     - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module cpg_downcnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cycle_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : cycle_pulse_gen
// Purpose  : Generates start/stop strobe pairs for the cycle timer. Each stop
//            follows its start by a programmed delay; bursts of pairs are
//            separated by a programmed gap. Supports early abort.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-high clear
//            trig_i    - starts a burst (sampled in IDLE)
//            delay_i   - start-to-stop distance in cycles
//            gap_i     - idle cycles between stop and next start
//            count_i   - pairs per burst (0 treated as 1)
//            abort_i   - terminate burst early
//            sig_start - one-cycle start strobe
//            sig_stop  - one-cycle stop strobe
//            busy      - burst in progress
//            done      - burst completed normally
//            pulse_idx - index of current pair
// Revision : 1.0 - initial release
// ============================================================================
module cycle_pulse_gen
  import cycle_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_W   = DEF_N_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [N_W-1:0]   count_i,
  input  logic             abort_i,
  output logic             sig_start,
  output logic             sig_stop,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   pulse_idx
);

  cpg_state_t       state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [N_W-1:0]   count_q, count_d;
  logic [N_W-1:0]   idx_q, idx_d;
  logic             abort_q, abort_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             stop_exit;
  logic             go_start;

  // The counter is loaded on the edge that enters START/GAP, so it already
  // holds delay-1 (gap-1) in that first cycle and reaches zero in the last
  // cycle before STOP (START). This places the stop exactly delay cycles
  // after the start, including delay = 2^CNT_W-1.
  cpg_downcnt #(
    .CNT_W (CNT_W)
  ) u_downcnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    gap_d     = gap_q;
    count_d   = count_q;
    idx_d     = idx_q;
    abort_d   = abort_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    stop_exit = 1'b0;
    go_start  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (trig_i && !abort_i) begin
          delay_d  = delay_i;
          gap_d    = gap_i;
          count_d  = (count_i == '0) ? N_W'(1) : count_i;
          idx_d    = '0;
          go_start = 1'b1;
        end
      end
      ST_START: begin
        // A zero delay folds the stop into the start cycle.
        if (delay_q == '0) begin
          stop_exit = 1'b1;
        end else if (abort_i) begin
          state_d = ST_STOP;
          abort_d = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_WAIT;
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        // Abort still issues the stop so the timer is never left running.
        if (abort_i) begin
          state_d = ST_STOP;
          abort_d = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_STOP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STOP: begin
        stop_exit = 1'b1;
      end
      ST_GAP: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          go_start = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving a cycle that carried a stop strobe.
    if (stop_exit) begin
      if (abort_i || abort_q) begin
        state_d = ST_IDLE;
      end else if (idx_q == count_q - N_W'(1)) begin
        state_d = ST_FIN;
      end else begin
        idx_d = idx_q + N_W'(1);
        if (gap_q == '0) begin
          go_start = 1'b1;
        end else begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = gap_q - CNT_W'(1);
        end
      end
    end

    if (go_start) begin
      state_d  = ST_START;
      cnt_load = 1'b1;
      cnt_val  = delay_d - CNT_W'(1);
    end
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      abort_q   <= 1'b0;
      sig_start <= 1'b0;
      sig_stop  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      abort_q   <= abort_d;
      sig_start <= (state_d == ST_START);
      sig_stop  <= (state_d == ST_STOP) ||
                   ((state_d == ST_START) && (delay_d == '0));
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_FIN);
    end
  end

  assign pulse_idx = idx_q;

endmodule
`default_nettype wire
